seq_pc_reg: RTL
===============

# seq_pc_reg

Architectural PC register and processor-status controller for the Y-86 SEQ core. It sits directly downstream of the next-PC selector and holds the committed PC that drives fetch. It decides each cycle whether the next-PC value is committed and tracks the Y-86 status code (AOK/HLT/ADR/INS). It also implements run/pause/single-step control and keeps cycle and retired-instruction counters for the testbench and debug.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; high = free-run, low = pause
- step  in  1  single-cycle pulse; commits one instruction while paused
- PC_new  in  64  next PC from the next-PC selector
- icode  in  4  icode of the instruction currently at PC
- instr_valid  in  1  fetch decoded a legal icode/ifun
- imem_error  in  1  fetch address out of range
- dmem_error  in  1  data-memory access out of range
- PC  out  64  committed PC, drives fetch
- stat  out  3  Y-86 status: 1=AOK, 2=HLT, 3=ADR, 4=INS
- halted  out  1  high in STOP state
- commit  out  1  registered pulse; high the cycle after a commit edge
- cycle_count  out  64  cycles spent in RUN
- retired_count  out  64  instructions retired

## Operation
- States:
  - IDLE: paused, the reset state.
  - RUN: commits every cycle.
  - STOP: terminal; left only by rst.
- Transitions:
  - IDLE→RUN when run=1. run has priority over step, so a simultaneous step is ignored and nothing commits on that edge.
  - IDLE with step=1 and run=0: one commit, then remain in IDLE.
  - RUN→IDLE when run=0. No commit occurs on that edge.
  - Any commit with a non-AOK status: →STOP.
- Status evaluation at a commit edge, highest priority first:
  1. imem_error → ADR
  2. !instr_valid → INS
  3. dmem_error → ADR
  4. icode==4'h0 (halt) → HLT
  5. otherwise AOK.
- Commit with AOK: PC←PC_new and retired_count+1.
- Commit with HLT: PC holds (keeps the halt address), retired_count+1, stat←HLT.
- Commit with ADR/INS: PC holds (keeps the faulting address), retired_count unchanged, stat←code.
- In STOP: PC, stat and counters are frozen, and run and step are ignored.
- cycle_count increments on every edge that begins in the RUN state.
- Both counters saturate at all-ones and never wrap.
- PC_new is taken verbatim with no alignment or masking; wrap-around of address arithmetic is upstream's concern.

## Timing
- Reset values, one edge after rst=1 is sampled:
  - PC=RESET_PC, stat=AOK, state IDLE
  - halted=0, commit=0, cycle_count=0, retired_count=0
- rst overrides every other input, including mid-run and while in STOP.
- Commit latency: PC_new is visible on PC one cycle after the commit edge. commit pulses high in that same cycle.
- stat and halted update at the same edge as PC.
- Inputs are sampled only at rising edges.
- step is edge-qualified by level: a step held high for N cycles in IDLE gives N commits.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package y86_pkg holds:
  - STAT_AOK/HLT/ADR/INS codes
  - icode constants IHALT=0, IJXX=7, ICALL=8, IRET=9
  - the state enum {IDLE, RUN, STOP}
- One sub-module, sat_counter64: a 64-bit saturating counter with enable and sync clear, instantiated twice.

## Test plan
- Reset then idle: rst high 2 cycles, then run=0 for 5 cycles → PC=RESET_PC, stat=1, cycle_count=0, commit never high.
- Free run: run=1, PC_new=PC+2 each cycle for 4 cycles → PC sequence 0,2,4,6,8; retired_count=4; cycle_count=4.
- Single step: run=0, step pulsed twice with PC_new=0x40 then 0x80 → PC=0x40 then 0x80, state stays IDLE, retired_count=2. Run and step together → no commit, state RUN.
- Halt: run=1, icode=0 at PC=0x18 → stat=2, halted=1, PC stays 0x18, retired_count includes the halt. Later run or step toggling → no change.
- Faults:
  - imem_error with instr_valid=0 → stat=3 (ADR beats INS), PC frozen, retired_count unchanged.
  - Separately, instr_valid=0 alone → stat=4.
- Reset mid-run/after STOP: rst asserted while in RUN or STOP → next cycle PC=RESET_PC, stat=1, counters=0. Counter preloaded near max → saturates at 64'hFFFF_FFFF_FFFF_FFFF.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y-86 definitions: status codes, icode constants and the PC-controller state encoding.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pc_state_e;

endpackage

// File: rtl/seq_pc_reg_sat_counter64.sv
// 64-bit up-counter that sticks at all-ones; sync clear wins over load, load wins over count.
module sat_counter64 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        ld,
  input  logic [63:0] ld_val,
  output logic [63:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en && (q != {64{1'b1}})) begin
      q <= q + 64'd1;
    end
  end

endmodule

// File: rtl/seq_pc_reg.sv
// Committed-PC register and status controller for the Y-86 SEQ core, with run/pause/step
// control and saturating cycle / retired-instruction counters.
module seq_pc_reg
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic [63:0] PC_new,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  output logic [63:0] PC,
  output logic [2:0]  stat,
  output logic        halted,
  output logic        commit,
  output logic [63:0] cycle_count,
  output logic [63:0] retired_count
);

  pc_state_e  state;
  logic [2:0] nxt_stat;
  logic       do_commit;
  logic       retire_en;
  logic       cycle_en;

  // Fetch faults outrank decode faults, which outrank data faults, which outrank halt.
  function automatic logic [2:0] eval_stat(input logic       ime,
                                           input logic       ivld,
                                           input logic       dme,
                                           input logic [3:0] ic);
    if (ime)              return STAT_ADR;
    else if (!ivld)       return STAT_INS;
    else if (dme)         return STAT_ADR;
    else if (ic == IHALT) return STAT_HLT;
    else                  return STAT_AOK;
  endfunction

  always_comb begin
    nxt_stat  = eval_stat(imem_error, instr_valid, dmem_error, icode);
    do_commit = ((state == RUN) && run) || ((state == IDLE) && !run && step);
    retire_en = do_commit && ((nxt_stat == STAT_AOK) || (nxt_stat == STAT_HLT));
    cycle_en  = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      PC     <= RESET_PC;
      stat   <= STAT_AOK;
      halted <= 1'b0;
      commit <= 1'b0;
    end else begin
      commit <= do_commit;
      case (state)
        IDLE:    if (run)  state <= RUN;
        RUN:     if (!run) state <= IDLE;
        default: ;
      endcase
      // A non-AOK commit leaves PC on the halting/faulting instruction and locks the core.
      if (do_commit) begin
        stat <= nxt_stat;
        if (nxt_stat == STAT_AOK) begin
          PC <= PC_new;
        end else begin
          state  <= STOP;
          halted <= 1'b1;
        end
      end
    end
  end

  sat_counter64 u_cycle_cnt (
    .clk    (clk),
    .clr    (rst),
    .en     (cycle_en),
    .ld     (1'b0),
    .ld_val (64'h0),
    .q      (cycle_count)
  );

  sat_counter64 u_retired_cnt (
    .clk    (clk),
    .clr    (rst),
    .en     (retire_en),
    .ld     (1'b0),
    .ld_val (64'h0),
    .q      (retired_count)
  );

endmodule
